// File: rtl/thread_issue_scheduler.sv
// Round-robin issue scheduler for hardware thread contexts sharing one dispatch pipeline.
// Tracks in-flight threads, caps occupancy, flags illegal retires and supports a drain handshake.
module thread_issue_scheduler #(
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] req,
  input  logic [NUM_THREADS-1:0] halt_mask,
  input  logic                   stall,
  input  logic                   retire_valid,
  input  logic [ID_W-1:0]        retire_id,
  input  logic                   drain_req,
  output logic                   issue_valid,
  output logic [ID_W-1:0]        issue_id,
  output logic [NUM_THREADS-1:0] grant,
  output logic [NUM_THREADS-1:0] inflight,
  output logic [ID_W:0]          inflight_count,
  output logic                   drained,
  output logic                   err_retire
);

  localparam int unsigned CNT_W = ID_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [ID_W-1:0]        issue_id_q, issue_id_d;
  logic [NUM_THREADS-1:0] grant_q, grant_d;
  logic [NUM_THREADS-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]       inflight_count_q, inflight_count_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   drained_q, drained_d;
  logic                   err_retire_q, err_retire_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [ID_W-1:0]        winner;
  logic                   found;
  logic                   do_issue;
  logic                   retire_legal;
  int unsigned            idx;

  // Next-state, arbitration and in-flight bookkeeping
  always_comb begin
    state_d          = state_q;
    issue_valid_d    = 1'b0;
    issue_id_d       = issue_id_q;
    grant_d          = '0;
    inflight_d       = inflight_q;
    inflight_count_d = '0;
    rr_ptr_d         = rr_ptr_q;
    err_retire_d     = err_retire_q;
    winner           = '0;
    found            = 1'b0;
    idx              = 0;

    eligible = req & ~halt_mask & ~inflight_q;

    // First eligible thread at or after the round-robin pointer
    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_THREADS;
      if (!found && eligible[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end

    // Capacity uses the pre-retire count; freed slots become usable next cycle
    do_issue = (state_q == ST_RUN) && !drain_req && !stall && found &&
               (32'(inflight_count_q) < MAX_INFLIGHT);

    retire_legal = retire_valid && ({1'b0, retire_id} < CNT_W'(NUM_THREADS)) &&
                   inflight_q[retire_id];

    if (retire_legal) begin
      inflight_d[retire_id] = 1'b0;
    end else if (retire_valid) begin
      err_retire_d = 1'b1;
    end

    if (do_issue) begin
      issue_valid_d      = 1'b1;
      issue_id_d         = winner;
      grant_d            = NUM_THREADS'(1) << winner;
      inflight_d[winner] = 1'b1;
      rr_ptr_d           = ID_W'((32'(winner) + 1) % NUM_THREADS);
    end

    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      inflight_count_d = inflight_count_d + CNT_W'(inflight_d[k]);
    end

    unique case (state_q)
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (inflight_count_d == '0) state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    drained_d = (state_d == ST_DRAINED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      issue_valid_q    <= 1'b0;
      issue_id_q       <= '0;
      grant_q          <= '0;
      inflight_q       <= '0;
      inflight_count_q <= '0;
      rr_ptr_q         <= '0;
      drained_q        <= 1'b0;
      err_retire_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_valid_q    <= issue_valid_d;
      issue_id_q       <= issue_id_d;
      grant_q          <= grant_d;
      inflight_q       <= inflight_d;
      inflight_count_q <= inflight_count_d;
      rr_ptr_q         <= rr_ptr_d;
      drained_q        <= drained_d;
      err_retire_q     <= err_retire_d;
    end
  end

  assign issue_valid    = issue_valid_q;
  assign issue_id       = issue_id_q;
  assign grant          = grant_q;
  assign inflight       = inflight_q;
  assign inflight_count = inflight_count_q;
  assign drained        = drained_q;
  assign err_retire     = err_retire_q;

endmodule
